// File: rtl/tx_ctrl.sv
// rtl/tx_ctrl.sv - CPU-side FIFO and send/busy sequencer for the serial tx transmitter
//
// Ports:
//   ck, rst          clock (rising edge), asynchronous active-low reset
//   address, dataW   CPU bus address and write data
//   ce, weCPU        CPU bus cycle enable and write enable
//   stat             status word {8'h0, count, tmo, ovf, full, active}
//   sel              address decodes to this block (data or status register)
//   send, palavra    one-cycle start pulse and registered word to tx
//   busy             transmitter busy from tx
module tx_ctrl #(
    parameter int             DEPTH        = 4,
    parameter int             WIDTH        = 16,
    parameter logic [7:0]     ADDR_DATA    = 8'hFF,
    parameter logic [7:0]     ADDR_STAT    = 8'hFE,
    parameter int             BUSY_TIMEOUT = 7
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [7:0]       address,
    input  logic [WIDTH-1:0] dataW,
    input  logic             ce,
    input  logic             weCPU,
    output logic [15:0]      stat,
    output logic             sel,
    output logic             send,
    output logic [WIDTH-1:0] palavra,
    input  logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   palavra_q, palavra_d;
    logic               ovf_q, ovf_d;
    logic               tmo_q, tmo_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic               push_req, ctrl_wr, full, pop, push_ok, tmo_set;
    logic [3:0]         count4;

    assign push_req = ce & weCPU & (address == ADDR_DATA);
    assign ctrl_wr  = ce & weCPU & (address == ADDR_STAT);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = (state_q == IDLE) && (count_q != '0) && !busy;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);

    // Sequencer: pop into palavra, pulse send, then follow the busy handshake.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        palavra_d = palavra_q;
        tmo_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    palavra_d = mem_q[rd_ptr_q];
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_HI;
            end
            WAIT_HI: begin
                if (busy) begin
                    state_d = WAIT_LO;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    // tx never acknowledged: give up on this word.
                    if (tmo_cnt_d == TMO_W'(BUSY_TIMEOUT)) begin
                        tmo_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_LO: begin
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage, pointers, occupancy and sticky flags.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = dataW;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Clears first so a same-cycle set takes priority.
        if (ctrl_wr && dataW[2]) ovf_d = 1'b0;
        if (ctrl_wr && dataW[3]) tmo_d = 1'b0;
        if (push_req && full && !pop) ovf_d = 1'b1;
        if (tmo_set) tmo_d = 1'b1;
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            palavra_q <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            palavra_q <= palavra_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign count4  = 4'(count_q);
    assign stat    = {8'h00, count4, tmo_q, ovf_q, full, (state_q != IDLE) || (count_q != '0)};
    assign sel     = (address == ADDR_DATA) || (address == ADDR_STAT);
    assign send    = (state_q == LOAD);
    assign palavra = palavra_q;

endmodule

// File: tb/tb_tx_ctrl.sv
// tb/tb_tx_ctrl.sv - scoreboard bench for tx_ctrl with a behavioural tx busy model
module tb_tx_ctrl;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  address = 8'hFE;
    logic [15:0] dataW = 16'h0;
    logic        ce = 1'b0;
    logic        weCPU = 1'b0;
    logic        busy = 1'b0;
    logic [15:0] stat;
    logic        sel;
    logic        send;
    logic [15:0] palavra;

    int          checks = 0;
    int          errors = 0;
    int          n_sends = 0;
    logic [15:0] sb [$];
    bit          tx_auto = 1'b1;
    int          busy_len = 20;
    int          busy_cnt = 0;

    tx_ctrl dut (
        .ck(ck), .rst(rst), .address(address), .dataW(dataW), .ce(ce), .weCPU(weCPU),
        .stat(stat), .sel(sel), .send(send), .palavra(palavra), .busy(busy)
    );

    always #5 ck = ~ck;

    // Scoreboard check on every send pulse, plus the tx busy model.
    initial begin
        logic [15:0] exp_w;
        forever begin
            @(negedge ck);
            if (send === 1'b1) begin
                n_sends++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_send: palavra=%h, expected no send", palavra);
                end else begin
                    exp_w = sb.pop_front();
                    if (palavra !== exp_w) begin
                        errors++;
                        $display("FAIL sb_order: palavra=%h expected=%h", palavra, exp_w);
                    end
                end
            end
            if (tx_auto) begin
                if (send === 1'b1 && busy_len > 0) busy_cnt = busy_len;
                else if (busy_cnt > 0) busy_cnt--;
                busy = (busy_cnt > 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic idle_bus();
        address = 8'hFE; dataW = 16'h0; ce = 1'b0; weCPU = 1'b0;
    endtask

    task automatic push(input logic [15:0] w, input bit accept);
        address = 8'hFF; dataW = w; ce = 1'b1; weCPU = 1'b1;
        if (accept) sb.push_back(w);
        @(negedge ck);
        idle_bus();
    endtask

    task automatic ctrl_write(input logic [15:0] v);
        address = 8'hFE; dataW = v; ce = 1'b1; weCPU = 1'b1;
        @(negedge ck);
        idle_bus();
    endtask

    task automatic wait_drain(input int max_cyc, input logic [15:0] exp_stat);
        int k = 0;
        while (k < max_cyc && !(stat === exp_stat && sb.size() == 0 && busy === 1'b0)) begin
            @(negedge ck);
            k++;
        end
    endtask

    task automatic wait_send(input int max_cyc);
        int k = 0;
        while (k < max_cyc && send !== 1'b1) begin
            @(negedge ck);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; idle_bus();
        repeat (2) @(negedge ck);
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b expected 0", send); end
        checks++; if (palavra !== 16'h0) begin errors++; $display("FAIL reset_palavra: got %h expected 0000", palavra); end
        checks++; if (stat !== 16'h0) begin errors++; $display("FAIL reset_stat: got %h expected 0000", stat); end
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sel_stat: got %b expected 1", sel); end
        address = 8'h10; #1;
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL sel_other: got %b expected 0", sel); end
        address = 8'hFF; #1;
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sel_data: got %b expected 1", sel); end
        idle_bus();
        @(negedge ck); rst = 1'b1;
        repeat (2) @(negedge ck);
        checks++; if (stat !== 16'h0) begin errors++; $display("FAIL post_reset_stat: got %h expected 0000", stat); end
    endtask

    task automatic test_single();
        int s0 = n_sends;
        tx_auto = 1'b1; busy_len = 20;
        push(16'hA5C3, 1'b1);
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL single_c1_send: got %b expected 0", send); end
        checks++; if (stat !== 16'h0011) begin errors++; $display("FAIL single_c1_stat: got %h expected 0011", stat); end
        @(negedge ck);
        checks++; if (send !== 1'b1) begin errors++; $display("FAIL single_c2_send: got %b expected 1", send); end
        checks++; if (palavra !== 16'hA5C3) begin errors++; $display("FAIL single_palavra: got %h expected a5c3", palavra); end
        checks++; if (stat !== 16'h0001) begin errors++; $display("FAIL single_c2_stat: got %h expected 0001", stat); end
        @(negedge ck);
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b expected 0", send); end
        repeat (5) @(negedge ck);
        checks++; if (stat !== 16'h0001) begin errors++; $display("FAIL single_busy_stat: got %h expected 0001", stat); end
        checks++; if (palavra !== 16'hA5C3) begin errors++; $display("FAIL single_palavra_hold: got %h expected a5c3", palavra); end
        wait_drain(60, 16'h0000);
        checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL single_done_stat: got %h expected 0000", stat); end
        checks++; if (n_sends - s0 !== 1) begin errors++; $display("FAIL single_send_count: got %0d expected 1", n_sends - s0); end
    endtask

    task automatic test_burst_ovf();
        int s0 = n_sends;
        busy_len = 20;
        for (int i = 1; i <= 5; i++) push(16'(i), 1'b1);
        push(16'h0006, 1'b0);
        checks++; if (stat !== 16'h0047) begin errors++; $display("FAIL burst_ovf_stat: got %h expected 0047", stat); end
        wait_drain(400, 16'h0004);
        checks++; if (stat !== 16'h0004) begin errors++; $display("FAIL burst_drain_stat: got %h expected 0004", stat); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL burst_sb_left: got %0d expected 0", sb.size()); end
        checks++; if (n_sends - s0 !== 5) begin errors++; $display("FAIL burst_send_count: got %0d expected 5", n_sends - s0); end
    endtask

    task automatic test_ctrl_clear();
        int s0 = n_sends;
        ctrl_write(16'h0008);
        checks++; if (stat !== 16'h0004) begin errors++; $display("FAIL clr_tmo_keeps_ovf: got %h expected 0004", stat); end
        ctrl_write(16'h0004);
        checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL clr_ovf: got %h expected 0000", stat); end
        ctrl_write(16'h0008);
        checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL clr_tmo_noop: got %h expected 0000", stat); end
        address = 8'h10; dataW = 16'h1234; ce = 1'b1; weCPU = 1'b1;
        @(negedge ck);
        address = 8'hFF; ce = 1'b0;
        @(negedge ck);
        idle_bus();
        repeat (4) @(negedge ck);
        checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL other_write_stat: got %h expected 0000", stat); end
        checks++; if (n_sends !== s0) begin errors++; $display("FAIL other_write_send: got %0d expected %0d", n_sends, s0); end
    endtask

    task automatic test_timeout();
        busy_len = 0;
        push(16'h1111, 1'b1);
        push(16'h2222, 1'b1);
        wait_send(10);
        checks++; if (send !== 1'b1) begin errors++; $display("FAIL tmo_first_send: got %b expected 1", send); end
        repeat (7) @(negedge ck);
        checks++; if (stat !== 16'h0011) begin errors++; $display("FAIL tmo_before: got %h expected 0011", stat); end
        @(negedge ck);
        checks++; if (stat !== 16'h0019) begin errors++; $display("FAIL tmo_set: got %h expected 0019", stat); end
        @(negedge ck);
        checks++; if (send !== 1'b1) begin errors++; $display("FAIL tmo_next_send: got %b expected 1", send); end
        checks++; if (palavra !== 16'h2222) begin errors++; $display("FAIL tmo_next_word: got %h expected 2222", palavra); end
        checks++; if (stat !== 16'h0009) begin errors++; $display("FAIL tmo_next_stat: got %h expected 0009", stat); end
        repeat (8) @(negedge ck);
        checks++; if (stat !== 16'h0008) begin errors++; $display("FAIL tmo_second: got %h expected 0008", stat); end
        ctrl_write(16'h0008);
        checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL tmo_clear: got %h expected 0000", stat); end
    endtask

    task automatic test_push_pop_full();
        tx_auto = 1'b0; busy = 1'b0;
        push(16'h0101, 1'b1);
        wait_send(10);
        checks++; if (send !== 1'b1) begin errors++; $display("FAIL ppf_first_send: got %b expected 1", send); end
        busy = 1'b1;
        for (int i = 2; i <= 5; i++) push(16'(i * 16'h0101), 1'b1);
        checks++; if (stat !== 16'h0043) begin errors++; $display("FAIL ppf_full: got %h expected 0043", stat); end
        busy = 1'b0;
        @(negedge ck);
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL ppf_idle_send: got %b expected 0", send); end
        busy_len = 3; tx_auto = 1'b1;
        push(16'h0606, 1'b1);
        checks++; if (send !== 1'b1) begin errors++; $display("FAIL ppf_pop_send: got %b expected 1", send); end
        checks++; if (palavra !== 16'h0202) begin errors++; $display("FAIL ppf_pop_word: got %h expected 0202", palavra); end
        checks++; if (stat !== 16'h0043) begin errors++; $display("FAIL ppf_stat: got %h expected 0043", stat); end
        wait_drain(200, 16'h0000);
        checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL ppf_drain_stat: got %h expected 0000", stat); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL ppf_sb_left: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        int s0;
        tx_auto = 1'b1; busy_len = 20;
        for (int i = 0; i < 4; i++) push(16'h0A0A + 16'(i) * 16'h0101, 1'b1);
        repeat (2) @(negedge ck);
        checks++; if (stat !== 16'h0031) begin errors++; $display("FAIL rmid_before: got %h expected 0031", stat); end
        rst = 1'b0;
        #1;
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL rmid_send: got %b expected 0", send); end
        checks++; if (palavra !== 16'h0) begin errors++; $display("FAIL rmid_palavra: got %h expected 0000", palavra); end
        checks++; if (stat !== 16'h0) begin errors++; $display("FAIL rmid_stat: got %h expected 0000", stat); end
        sb.delete();
        s0 = n_sends;
        @(negedge ck); rst = 1'b1;
        repeat (30) @(negedge ck);
        checks++; if (n_sends !== s0) begin errors++; $display("FAIL rmid_no_send: got %0d expected %0d", n_sends, s0); end
        checks++; if (stat !== 16'h0) begin errors++; $display("FAIL rmid_idle_stat: got %h expected 0000", stat); end
        push(16'h0E0E, 1'b1);
        wait_drain(60, 16'h0000);
        checks++; if (n_sends - s0 !== 1) begin errors++; $display("FAIL rmid_new_send: got %0d expected 1", n_sends - s0); end
        checks++; if (stat !== 16'h0000) begin errors++; $display("FAIL rmid_final_stat: got %h expected 0000", stat); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_ovf();
        test_ctrl_clear();
        test_timeout();
        test_push_pop_full();
        test_reset_mid();
        repeat (2) @(negedge ck);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
